coarse_track_seq: RTL and testbench

- Digital sequencer wrapped around the coarse resolver summing network.
- Once per tick it decodes the read-counter angle into the sector and reference switch drives, waits for the analog sum to settle, then debounces the two error comparators.
- It then requests up or down counter steps over a req/ack handshake until the error nulls.
- Successor to the fixed 12-switch coarse stage: reference-ladder depth, settle time, debounce depth and slew limit are parametrised, and stepping, lock and fault sequencing are added.

---
 rtl/coarse_pkg.sv | 39 +++
 rtl/coarse_debounce.sv | 59 +++++
 rtl/coarse_track_seq.sv | 183 ++++++++++++++++++
 tb/tb_coarse_track_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coarse_pkg.sv
// Shared types and constants for the coarse resolver tracking sequencer.
package coarse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_STEP
    } state_t;

    localparam int S1 = 0;
    localparam int S2 = 1;
    localparam int S3 = 2;
    localparam int S4 = 3;
    localparam int S5 = 4;
    localparam int S6 = 5;
    localparam int S7 = 6;
    localparam int S8 = 7;

    // Octant q selects the sin/cos switch pair closed on the summing network.
    localparam logic [7:0] SECTOR_SC [8] = '{
        8'((1 << S3) | (1 << S5)),
        8'((1 << S4) | (1 << S6)),
        8'((1 << S2) | (1 << S6)),
        8'((1 << S1) | (1 << S5)),
        8'((1 << S1) | (1 << S7)),
        8'((1 << S2) | (1 << S8)),
        8'((1 << S4) | (1 << S8)),
        8'((1 << S3) | (1 << S7))
    };

    // Comparator sample packing: {adhi, err_hi, err_lo}.
    localparam int VERDICT_W = 3;
    localparam int V_LO      = 0;
    localparam int V_HI      = 1;
    localparam int V_ADHI    = 2;

endpackage

// File: rtl/coarse_debounce.sv
// Comparator debouncer: accepts a sample after DEPTH identical consecutive
// samples; flags a timeout when 4*DEPTH samples pass without acceptance.
module coarse_debounce #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic         accept_o,
    output logic [W-1:0] verdict_o,
    output logic         timeout_o
);

    localparam int AW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(4 * DEPTH + 1);

    logic [W-1:0]  hist_q, hist_d;
    logic [AW-1:0] agree_q, agree_d;
    logic [TW-1:0] left_q, left_d;

    always_comb begin
        hist_d  = hist_q;
        agree_d = agree_q;
        left_d  = left_q;
        if (en_i) begin
            hist_d = din_i;
            if ((agree_q != '0) && (din_i == hist_q)) begin
                if (agree_q != AW'(DEPTH)) begin
                    agree_d = agree_q + AW'(1);
                end
            end else begin
                agree_d = AW'(1);
            end
            if (left_q != '0) begin
                left_d = left_q - TW'(1);
            end
        end
    end

    assign accept_o  = en_i && (agree_d == AW'(DEPTH));
    assign timeout_o = en_i && !accept_o && (left_q == '0);
    assign verdict_o = din_i;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            hist_q  <= '0;
            agree_q <= '0;
            left_q  <= TW'(4 * DEPTH - 1);
        end else begin
            hist_q  <= hist_d;
            agree_q <= agree_d;
            left_q  <= left_d;
        end
    end

endmodule

// File: rtl/coarse_track_seq.sv
// Coarse resolver tracking sequencer: sector/ladder drive, settle wait,
// comparator debounce and up/down step handshake with lock/fault flags.
//
// state  | meaning
// IDLE   | waiting for tick with enable
// DRIVE  | latch angle, update sin/cos and ladder switches
// SETTLE | wait for the analog sum to settle
// SAMPLE | debounce err_hi/err_lo/adhi into a verdict
// STEP   | step request held until the counter acks
module coarse_track_seq
    import coarse_pkg::*;
#(
    parameter int ANGLE_W    = 16,
    parameter int LEVEL_BITS = 4,
    parameter int SETTLE_CYC = 8,
    parameter int DEBOUNCE   = 4,
    parameter int MAX_STEPS  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  tick,
    input  logic [ANGLE_W-1:0]    angle,
    input  logic                  err_hi,
    input  logic                  err_lo,
    input  logic                  adhi,
    output logic [7:0]            dc_sc,
    output logic [LEVEL_BITS-1:0] dc_ref,
    output logic                  step_req,
    output logic                  step_dir,
    input  logic                  step_ack,
    output logic                  locked,
    output logic                  no_lock,
    output logic                  err_both
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int CW = $clog2(MAX_STEPS + 1);

    state_t                state_q, state_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [CW-1:0]         steps_q, steps_d;
    logic [7:0]            dc_sc_q, dc_sc_d;
    logic [LEVEL_BITS-1:0] dc_ref_q, dc_ref_d;
    logic                  step_req_q, step_req_d;
    logic                  step_dir_q, step_dir_d;
    logic                  locked_q, locked_d;
    logic                  no_lock_q, no_lock_d;
    logic                  err_both_q, err_both_d;

    logic [VERDICT_W-1:0]  verdict;
    logic                  db_accept, db_timeout, db_en, db_clr;
    logic [2:0]            sector;
    logic                  angle_unused;

    assign sector       = angle[ANGLE_W-1 -: 3];
    assign angle_unused = ^angle;
    assign db_en        = enable && (state_q == ST_SAMPLE);
    assign db_clr       = (state_q != ST_SAMPLE);

    coarse_debounce #(
        .W     (VERDICT_W),
        .DEPTH (DEBOUNCE)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (db_clr),
        .en_i      (db_en),
        .din_i     ({adhi, err_hi, err_lo}),
        .accept_o  (db_accept),
        .verdict_o (verdict),
        .timeout_o (db_timeout)
    );

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        steps_d    = steps_q;
        dc_sc_d    = dc_sc_q;
        dc_ref_d   = dc_ref_q;
        step_req_d = step_req_q;
        step_dir_d = step_dir_q;
        locked_d   = locked_q;
        no_lock_d  = no_lock_q;
        err_both_d = err_both_q;

        if (!enable) begin
            state_d    = ST_IDLE;
            dc_sc_d    = '0;
            dc_ref_d   = '0;
            step_req_d = 1'b0;
            locked_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    dc_sc_d  = SECTOR_SC[sector];
                    dc_ref_d = angle[ANGLE_W-4 -: LEVEL_BITS];
                    settle_d = SW'(SETTLE_CYC - 1);
                    state_d  = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        settle_d = settle_q - SW'(1);
                    end
                end
                ST_SAMPLE: begin
                    // Ambiguity forces an up step regardless of the error comparators.
                    if (db_accept && (verdict[V_ADHI] || (verdict[V_HI] != verdict[V_LO]))) begin
                        step_req_d = 1'b1;
                        step_dir_d = verdict[V_ADHI] || verdict[V_HI];
                        locked_d   = 1'b0;
                        state_d    = ST_STEP;
                    end else if (db_accept && verdict[V_HI]) begin
                        err_both_d = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = ST_IDLE;
                    end else if (db_accept || db_timeout) begin
                        locked_d   = 1'b1;
                        steps_d    = '0;
                        state_d    = ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (step_ack) begin
                        step_req_d = 1'b0;
                        if (steps_q != CW'(MAX_STEPS)) begin
                            steps_d = steps_q + CW'(1);
                        end
                        if (steps_q >= CW'(MAX_STEPS - 1)) begin
                            no_lock_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            state_d   = ST_DRIVE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            steps_q    <= '0;
            dc_sc_q    <= '0;
            dc_ref_q   <= '0;
            step_req_q <= 1'b0;
            step_dir_q <= 1'b0;
            locked_q   <= 1'b0;
            no_lock_q  <= 1'b0;
            err_both_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            steps_q    <= steps_d;
            dc_sc_q    <= dc_sc_d;
            dc_ref_q   <= dc_ref_d;
            step_req_q <= step_req_d;
            step_dir_q <= step_dir_d;
            locked_q   <= locked_d;
            no_lock_q  <= no_lock_d;
            err_both_q <= err_both_d;
        end
    end

    assign dc_sc    = dc_sc_q;
    assign dc_ref   = dc_ref_q;
    assign step_req = step_req_q;
    assign step_dir = step_dir_q;
    assign locked   = locked_q;
    assign no_lock  = no_lock_q;
    assign err_both = err_both_q;

endmodule

// File: tb/tb_coarse_track_seq.sv
// Bench for coarse_track_seq: a procedural window model predicts every output
// each cycle, and directed scenarios pin key values with literal expectations.
module tb_coarse_track_seq;

    localparam int SETTLE = 8;
    localparam int DEB    = 4;
    localparam int MAXS   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, enable = 1'b0, tick = 1'b0;
    logic [15:0] angle = '0;
    logic        err_hi = 1'b0, err_lo = 1'b0, adhi = 1'b0, step_ack = 1'b0;
    logic [7:0]  dc_sc;
    logic [3:0]  dc_ref;
    logic        step_req, step_dir, locked, no_lock, err_both;

    int checks = 0;
    int errors = 0;
    int req_rises = 0;
    int base = 0;
    bit check_en = 1'b0;
    logic prev_req = 1'b0;

    logic [7:0] exp_sc = '0;
    logic [3:0] exp_ref = '0;
    bit exp_req = 0, exp_dir = 0, exp_locked = 0, exp_nolock = 0, exp_both = 0;
    int m_steps = 0;

    logic [7:0] SC_TBL [8] = '{8'h14, 8'h28, 8'h22, 8'h11, 8'h41, 8'h82, 8'h88, 8'h44};

    always #5 clk = ~clk;

    coarse_track_seq #(
        .ANGLE_W    (16),
        .LEVEL_BITS (4),
        .SETTLE_CYC (SETTLE),
        .DEBOUNCE   (DEB),
        .MAX_STEPS  (MAXS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .tick     (tick),
        .angle    (angle),
        .err_hi   (err_hi),
        .err_lo   (err_lo),
        .adhi     (adhi),
        .dc_sc    (dc_sc),
        .dc_ref   (dc_ref),
        .step_req (step_req),
        .step_dir (step_dir),
        .step_ack (step_ack),
        .locked   (locked),
        .no_lock  (no_lock),
        .err_both (err_both)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_edge(output bit ab);
        @(posedge clk);
        ab = !rst_n || !enable;
        if (!rst_n) begin
            exp_nolock = 0; exp_both = 0; exp_dir = 0; m_steps = 0;
        end
        if (ab) begin
            exp_sc = '0; exp_ref = '0; exp_req = 0; exp_locked = 0;
        end
    endtask

    task automatic m_window();
        bit ab;
        logic [2:0] v, last;
        int run, n;
        bit done;
        forever begin
            m_edge(ab); if (ab) return;
            exp_sc  = SC_TBL[angle[15:13]];
            exp_ref = angle[12:9];
            repeat (SETTLE) begin m_edge(ab); if (ab) return; end
            run = 0; n = 0; done = 0; last = '0; v = '0;
            while (!done) begin
                m_edge(ab); if (ab) return;
                v = {adhi, err_hi, err_lo};
                n++;
                run = (run > 0 && v == last) ? run + 1 : 1;
                last = v;
                if (run == DEB) done = 1;
                else if (n == 4 * DEB) begin done = 1; v = 3'b000; end
            end
            if (v[2] || (v[1] != v[0])) begin
                exp_locked = 0; exp_req = 1; exp_dir = v[2] | v[1];
                do begin m_edge(ab); if (ab) return; end while (!step_ack);
                exp_req = 0;
                if (m_steps >= MAXS - 1) begin exp_nolock = 1; return; end
                m_steps++;
            end else if (v[1]) begin
                exp_both = 1; exp_locked = 0; return;
            end else begin
                exp_locked = 1; m_steps = 0; return;
            end
        end
    endtask

    initial begin : model
        bit ab;
        forever begin
            do m_edge(ab); while (ab || !tick);
            m_window();
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("dc_sc",    32'(dc_sc),    32'(exp_sc));
            chk("dc_ref",   32'(dc_ref),   32'(exp_ref));
            chk("step_req", 32'(step_req), 32'(exp_req));
            chk("locked",   32'(locked),   32'(exp_locked));
            chk("no_lock",  32'(no_lock),  32'(exp_nolock));
            chk("err_both", 32'(err_both), 32'(exp_both));
            if (exp_req) chk("step_dir", 32'(step_dir), 32'(exp_dir));
            if (step_req && !prev_req) req_rises++;
        end
        prev_req = step_req;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst_n = 0; enable = 0; tick = 0; err_hi = 0; err_lo = 0; adhi = 0;
        step_ack = 0; angle = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic pulse_tick();
        tick = 1;
        @(negedge clk);
        tick = 0;
    endtask

    task automatic wait_req();
        int t = 0;
        while (!step_req && t < 100) begin @(negedge clk); t++; end
        chk("req_seen", 32'(step_req), 32'd1);
    endtask

    task automatic ack_step(input int d, input bit want_dir);
        wait_req();
        chk("req_dir", 32'(step_dir), 32'(want_dir));
        repeat (d) begin
            @(negedge clk);
            chk("req_hold", 32'(step_req), 32'd1);
        end
        step_ack = 1;
        @(negedge clk);
        step_ack = 0;
        chk("req_drop", 32'(step_req), 32'd0);
    endtask

    task automatic wait_locked(input string nm);
        int t = 0;
        while (!locked && t < 60) begin @(negedge clk); t++; end
        chk(nm, 32'(locked), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, want finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- scenarios ----------------
    initial begin : main
        do_reset();
        check_en = 1;
        chk("rst_dc_sc",    32'(dc_sc),    32'd0);
        chk("rst_dc_ref",   32'(dc_ref),   32'd0);
        chk("rst_step_req", 32'(step_req), 32'd0);
        chk("rst_locked",   32'(locked),   32'd0);
        chk("rst_no_lock",  32'(no_lock),  32'd0);
        chk("rst_err_both", 32'(err_both), 32'd0);

        // sector decode and null latency
        enable = 1;
        base = req_rises;
        for (int q = 0; q < 8; q++) begin
            angle = 16'(q << 13);
            pulse_tick();
            @(negedge clk);
            chk("sector_sc",  32'(dc_sc),  32'(SC_TBL[q]));
            chk("sector_ref", 32'(dc_ref), 32'd0);
            for (int i = 2; i <= 14; i++) begin
                @(negedge clk);
                if (i == 12) chk("null_early", 32'(locked), 32'd0);
                if (i == 13) chk("null_lock",  32'(locked), 32'd1);
            end
            enable = 0;
            @(negedge clk);
            enable = 1;
        end
        angle = 16'hA5F0;
        pulse_tick();
        @(negedge clk);
        chk("angle_sc",  32'(dc_sc),  32'h82);
        chk("angle_ref", 32'(dc_ref), 32'h2);
        repeat (14) @(negedge clk);
        chk("null_no_step", 32'(req_rises - base), 32'd0);

        // tracking up with delayed acks
        do_reset();
        enable = 1; err_hi = 1; base = req_rises;
        pulse_tick();
        ack_step(0, 1'b1);
        ack_step(3, 1'b1);
        ack_step(10, 1'b1);
        err_hi = 0;
        wait_locked("track_lock");
        chk("track_reqs", 32'(req_rises - base), 32'd3);

        // glitching err_lo times out as a null
        do_reset();
        enable = 1; base = req_rises;
        pulse_tick();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            err_lo = ((i / 2) % 2) != 0;
            if (i == 23) chk("glitch_early",   32'(locked), 32'd0);
            if (i == 24) chk("glitch_timeout", 32'(locked), 32'd1);
        end
        err_lo = 0;
        chk("glitch_no_step", 32'(req_rises - base), 32'd0);

        // ambiguity overrides err_lo
        do_reset();
        enable = 1; adhi = 1; err_lo = 1; base = req_rises;
        pulse_tick();
        ack_step(2, 1'b1);
        adhi = 0; err_lo = 0;
        wait_locked("ambig_lock");
        chk("ambig_reqs", 32'(req_rises - base), 32'd1);

        // slew-limit fault
        do_reset();
        enable = 1; err_lo = 1; base = req_rises;
        pulse_tick();
        for (int k = 0; k < 4; k++) begin
            ack_step(1, 1'b0);
            if (k == 2) chk("nolock_early", 32'(no_lock), 32'd0);
        end
        chk("nolock_set",    32'(no_lock), 32'd1);
        chk("nolock_unlock", 32'(locked),  32'd0);
        repeat (20) @(negedge clk);
        chk("nolock_idle",   32'(step_req), 32'd0);
        chk("nolock_reqs",   32'(req_rises - base), 32'd4);
        err_lo = 0; enable = 0;
        @(negedge clk);
        enable = 1;
        @(negedge clk);
        chk("nolock_sticky", 32'(no_lock), 32'd1);

        // both comparators
        do_reset();
        enable = 1; err_hi = 1; err_lo = 1; base = req_rises;
        pulse_tick();
        repeat (20) @(negedge clk);
        chk("both_set",     32'(err_both), 32'd1);
        chk("both_no_step", 32'(req_rises - base), 32'd0);
        chk("both_unlock",  32'(locked), 32'd0);
        err_hi = 0; err_lo = 0;

        // reset mid-SETTLE clears sticky flags too
        angle = 16'(1 << 13);
        pulse_tick();
        repeat (3) @(negedge clk);
        chk("settle_dc",   32'(dc_sc),    32'h28);
        chk("settle_both", 32'(err_both), 32'd1);
        rst_n = 0;
        @(negedge clk);
        chk("rst2_dc_sc",    32'(dc_sc),    32'd0);
        chk("rst2_dc_ref",   32'(dc_ref),   32'd0);
        chk("rst2_step_req", 32'(step_req), 32'd0);
        chk("rst2_locked",   32'(locked),   32'd0);
        chk("rst2_err_both", 32'(err_both), 32'd0);
        rst_n = 1;

        // disable during STEP
        do_reset();
        enable = 1; err_hi = 1; angle = 16'(3 << 13);
        pulse_tick();
        wait_req();
        chk("dis_dc_before", 32'(dc_sc), 32'h11);
        enable = 0;
        @(negedge clk);
        chk("dis_req",   32'(step_req), 32'd0);
        chk("dis_dc_sc", 32'(dc_sc),    32'd0);
        enable = 1; err_hi = 0;

        // tick during SAMPLE is ignored
        do_reset();
        enable = 1; angle = '0;
        pulse_tick();
        repeat (10) @(negedge clk);
        angle = 16'(7 << 13);
        pulse_tick();
        repeat (2) @(negedge clk);
        chk("busy_tick_lock", 32'(locked), 32'd1);
        chk("busy_tick_dc",   32'(dc_sc),  32'h14);
        repeat (5) @(negedge clk);
        chk("busy_tick_hold", 32'(dc_sc),  32'h14);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
